// File: rtl/mips_pkg.sv
//==============================================================================
// Module      : mips_pkg
// Description : Shared MIPS definitions for the decode/register-read stage:
//               opcode and funct constants, the link register index, the
//               operand-fetch state type and an instruction decode helper
//               that classifies register usage and builds the immediate.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package mips_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] FUNCT_JR = 6'h08;

    // Link register written by jal
    localparam logic [4:0] REG_RA = 5'd31;

    // Output-register occupancy
    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } of_state_e;

    // Decoded view of one instruction word
    typedef struct packed {
        logic        use_rs;
        logic        use_rt;
        logic [4:0]  dest;
        logic        dest_en;
        logic [31:0] imm;
    } decode_t;

    // Classify register usage and form the extended immediate.
    // Unknown opcodes fall through with no sources and no destination.
    function automatic decode_t decode_instr(input logic [31:0] instr);
        decode_t    d;
        logic [5:0] op;
        logic [5:0] funct;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [15:0] imm16;

        op    = instr[31:26];
        funct = instr[5:0];
        rt    = instr[20:16];
        rd    = instr[15:11];
        imm16 = instr[15:0];

        d.use_rs  = 1'b0;
        d.use_rt  = 1'b0;
        d.dest    = 5'd0;
        d.dest_en = 1'b0;
        d.imm     = {{16{imm16[15]}}, imm16};

        case (op)
            OP_RTYPE: begin
                d.use_rs  = 1'b1;
                d.use_rt  = 1'b1;
                d.dest    = rd;
                d.dest_en = (funct != FUNCT_JR);
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_LW: begin
                d.use_rs  = 1'b1;
                d.dest    = rt;
                d.dest_en = 1'b1;
            end
            OP_ANDI, OP_ORI: begin
                d.use_rs  = 1'b1;
                d.dest    = rt;
                d.dest_en = 1'b1;
                d.imm     = {16'h0000, imm16};
            end
            OP_LUI: begin
                d.dest    = rt;
                d.dest_en = 1'b1;
                d.imm     = {imm16, 16'h0000};
            end
            OP_SW, OP_BEQ, OP_BNE: begin
                d.use_rs  = 1'b1;
                d.use_rt  = 1'b1;
            end
            OP_J: begin
                d.imm     = {6'd0, instr[25:0]};
            end
            OP_JAL: begin
                d.dest    = REG_RA;
                d.dest_en = 1'b1;
                d.imm     = {6'd0, instr[25:0]};
            end
            default: begin
            end
        endcase

        // r0 is hard-wired, so nothing ever waits on it
        if (d.dest == 5'd0) begin
            d.dest_en = 1'b0;
        end
        return d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_2r1w.sv
//==============================================================================
// Module      : regfile_2r1w
// Description : Architectural register file, 2**REG_AW x DATA_W, two
//               asynchronous read ports and one synchronous write port.
//               Register 0 reads as zero and ignores writes. A synchronous
//               active-low reset clears every entry.
// Ports       : clock, reset_n          - clock / synchronous active-low reset
//               i_wr_en/i_wr_addr/i_wr_data - write port (takes effect at edge)
//               i_rd0_addr -> o_rd0_data - read port 0
//               i_rd1_addr -> o_rd1_data - read port 1
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module regfile_2r1w #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              i_wr_en,
    input  logic [REG_AW-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [REG_AW-1:0] i_rd0_addr,
    output logic [DATA_W-1:0] o_rd0_data,
    input  logic [REG_AW-1:0] i_rd1_addr,
    output logic [DATA_W-1:0] o_rd1_data
);

    localparam int c_NREGS = 2 ** REG_AW;

    logic [DATA_W-1:0] r_mem [c_NREGS];

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < c_NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en && (i_wr_addr != '0)) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Reads return the pre-edge contents; a same-cycle write is not forwarded
    assign o_rd0_data = (i_rd0_addr == '0) ? '0 : r_mem[i_rd0_addr];
    assign o_rd1_data = (i_rd1_addr == '0) ? '0 : r_mem[i_rd1_addr];

endmodule

`default_nettype wire

// File: rtl/operand_fetch.sv
//==============================================================================
// Module      : operand_fetch
// Description : MIPS decode/register-read stage. Accepts one instruction per
//               cycle from fetch, decodes register fields and immediate, reads
//               two operands from the owned register file and presents a
//               registered operand bundle to execute. A pending-write
//               scoreboard stalls instructions whose sources have an issued
//               but not yet written-back producer.
// Config      : `define OPERAND_FETCH_BYPASS_EN to forward the same-cycle
//               write-back value into the operands and suppress that hazard.
//               Default build has no bypass path.
// Ports       : clock, reset_n              - clock / synchronous active-low reset
//               in_valid/in_ready/in_instr  - fetch handshake
//               out_valid/out_ready         - execute handshake
//               out_opcode/out_funct/out_rs_val/out_rt_val/out_imm/
//               out_dest/out_dest_en        - registered operand bundle
//               wb_en/wb_addr/wb_data       - register-file write port
//               stall                       - in_valid blocked by a hazard
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module operand_fetch
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [5:0]        out_opcode,
    output logic [5:0]        out_funct,
    output logic [DATA_W-1:0] out_rs_val,
    output logic [DATA_W-1:0] out_rt_val,
    output logic [DATA_W-1:0] out_imm,
    output logic [REG_AW-1:0] out_dest,
    output logic              out_dest_en,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              stall
);

    localparam int c_NREGS = 2 ** REG_AW;

    // Decode
    decode_t           w_dec;
    logic [REG_AW-1:0] w_rs_addr;
    logic [REG_AW-1:0] w_rt_addr;
    logic [REG_AW-1:0] w_dest;

    assign w_dec     = decode_instr(in_instr);
    assign w_rs_addr = REG_AW'(in_instr[25:21]);
    assign w_rt_addr = REG_AW'(in_instr[20:16]);
    assign w_dest    = REG_AW'(w_dec.dest);

    // Register file
    logic [DATA_W-1:0] w_rf_rs;
    logic [DATA_W-1:0] w_rf_rt;

    regfile_2r1w #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_regfile (
        .clock      (clock),
        .reset_n    (reset_n),
        .i_wr_en    (wb_en),
        .i_wr_addr  (wb_addr),
        .i_wr_data  (wb_data),
        .i_rd0_addr (w_rs_addr),
        .o_rd0_data (w_rf_rs),
        .i_rd1_addr (w_rt_addr),
        .o_rd1_data (w_rf_rt)
    );

    // Bypass: a same-cycle write-back satisfies a used source, unless this
    // very instruction re-targets that register (it then waits one cycle so
    // its own scoreboard set does not race the clear).
    logic w_rs_byp;
    logic w_rt_byp;

`ifdef OPERAND_FETCH_BYPASS_EN
    assign w_rs_byp = w_dec.use_rs && wb_en && (wb_addr == w_rs_addr) &&
                      (w_rs_addr != '0) && !(w_dec.dest_en && (w_dest == w_rs_addr));
    assign w_rt_byp = w_dec.use_rt && wb_en && (wb_addr == w_rt_addr) &&
                      (w_rt_addr != '0) && !(w_dec.dest_en && (w_dest == w_rt_addr));
`else
    assign w_rs_byp = 1'b0;
    assign w_rt_byp = 1'b0;
`endif

    logic [DATA_W-1:0] w_rs_val;
    logic [DATA_W-1:0] w_rt_val;

    assign w_rs_val = w_rs_byp ? wb_data : w_rf_rs;
    assign w_rt_val = w_rt_byp ? wb_data : w_rf_rt;

    // Scoreboard and hazard
    logic [c_NREGS-1:0] r_pending;
    logic               w_hazard;
    logic               w_accept;
    of_state_e          r_state;

    assign w_hazard = (w_dec.use_rs && r_pending[w_rs_addr] && !w_rs_byp) ||
                      (w_dec.use_rt && r_pending[w_rt_addr] && !w_rt_byp);

    assign out_valid = (r_state == ST_FULL);
    assign in_ready  = (!out_valid || out_ready) && !w_hazard;
    assign w_accept  = in_valid && in_ready;
    assign stall     = in_valid && w_hazard;

    logic [c_NREGS-1:0] w_pend_set;
    logic [c_NREGS-1:0] w_pend_clr;

    always_comb begin
        w_pend_set = '0;
        w_pend_clr = '0;
        if (w_accept && w_dec.dest_en) begin
            w_pend_set[w_dest] = 1'b1;
        end
        if (wb_en) begin
            w_pend_clr[wb_addr] = 1'b1;
        end
    end

    // Set applied after clear so a same-cycle set/clear leaves the bit set
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_pend_clr) | w_pend_set;
        end
    end

    // Output register and occupancy state
    logic [5:0]        r_opcode;
    logic [5:0]        r_funct;
    logic [DATA_W-1:0] r_rs_val;
    logic [DATA_W-1:0] r_rt_val;
    logic [DATA_W-1:0] r_imm;
    logic [REG_AW-1:0] r_dest;
    logic              r_dest_en;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state   <= ST_EMPTY;
            r_opcode  <= '0;
            r_funct   <= '0;
            r_rs_val  <= '0;
            r_rt_val  <= '0;
            r_imm     <= '0;
            r_dest    <= '0;
            r_dest_en <= 1'b0;
        end else begin
            // Acceptance in FULL implies out_ready, so a load never
            // overwrites an unconsumed bundle.
            if (w_accept) begin
                r_opcode  <= in_instr[31:26];
                r_funct   <= in_instr[5:0];
                r_rs_val  <= w_rs_val;
                r_rt_val  <= w_rt_val;
                r_imm     <= DATA_W'(w_dec.imm);
                r_dest    <= w_dest;
                r_dest_en <= w_dec.dest_en;
            end
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_state <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (!w_accept && out_ready) begin
                        r_state <= ST_EMPTY;
                    end
                end
                default: begin
                    r_state <= ST_EMPTY;
                end
            endcase
        end
    end

    assign out_opcode  = r_opcode;
    assign out_funct   = r_funct;
    assign out_rs_val  = r_rs_val;
    assign out_rt_val  = r_rt_val;
    assign out_imm     = r_imm;
    assign out_dest    = r_dest;
    assign out_dest_en = r_dest_en;

endmodule

`default_nettype wire

// File: tb/tb_operand_fetch.sv
//==============================================================================
// Module      : tb_operand_fetch
// Description : Self-checking bench for operand_fetch. Directed scenarios
//               followed by random traffic; a reference model predicts the
//               handshake each cycle and queues expected bundles, which a
//               separate monitor compares against the DUT outputs.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_operand_fetch;

`ifdef OPERAND_FETCH_BYPASS_EN
    localparam bit c_BYP = 1'b1;
`else
    localparam bit c_BYP = 1'b0;
`endif

    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_opcode;
    logic [5:0]  out_funct;
    logic [31:0] out_rs_val;
    logic [31:0] out_rt_val;
    logic [31:0] out_imm;
    logic [4:0]  out_dest;
    logic        out_dest_en;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        stall;

    operand_fetch #(.DATA_W(32), .REG_AW(5)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_opcode  (out_opcode),
        .out_funct   (out_funct),
        .out_rs_val  (out_rs_val),
        .out_rt_val  (out_rt_val),
        .out_imm     (out_imm),
        .out_dest    (out_dest),
        .out_dest_en (out_dest_en),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .stall       (stall)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    typedef struct {
        logic [5:0]  opcode;
        logic [5:0]  funct;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        bit          use_rs;
        bit          use_rt;
        logic [31:0] imm;
        logic [4:0]  dest;
        bit          dest_en;
    } bundle_t;

    bundle_t     exp_q[$];
    logic [31:0] m_regs [32];
    bit          m_pend [32];
    bit          m_full;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 32'd0;
            m_pend[i] = 1'b0;
        end
        m_full = 1'b0;
        exp_q.delete();
    endtask

    // Architectural meaning of an instruction, straight from the ISA table
    function automatic bundle_t ref_meaning(input logic [31:0] ins);
        bundle_t b;
        logic [5:0] op;
        bit writes_rt;
        op = ins[31:26];
        writes_rt = op inside {6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0F, 6'h23};
        b.opcode  = op;
        b.funct   = ins[5:0];
        b.use_rs  = (op == 6'h00) || (op inside {6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h05});
        b.use_rt  = op inside {6'h00, 6'h2B, 6'h04, 6'h05};
        b.dest    = (op == 6'h00) ? ins[15:11] : (op == 6'h03) ? 5'd31 : ins[20:16];
        b.dest_en = ((op == 6'h00) && (ins[5:0] != 6'h08)) || writes_rt || (op == 6'h03);
        if (b.dest == 5'd0) b.dest_en = 1'b0;
        if (op == 6'h0C || op == 6'h0D)      b.imm = {16'h0, ins[15:0]};
        else if (op == 6'h0F)                b.imm = {ins[15:0], 16'h0};
        else if (op == 6'h02 || op == 6'h03) b.imm = ins & 32'h03FF_FFFF;
        else                                 b.imm = ins[15] ? {16'hFFFF, ins[15:0]} : {16'h0, ins[15:0]};
        b.rs_val = 32'd0;
        b.rt_val = 32'd0;
        return b;
    endfunction

    // One clock of stimulus; inputs are applied just after a rising edge
    task automatic cycle(input bit v, input logic [31:0] ins, input bit ordy,
                         input bit we, input logic [4:0] wa, input logic [31:0] wd,
                         output bit acc);
        bundle_t b;
        logic [4:0] rs, rt;
        bit byp_rs, byp_rt, haz, exp_rdy;
        in_valid  = v;
        in_instr  = ins;
        out_ready = ordy;
        wb_en     = we;
        wb_addr   = wa;
        wb_data   = wd;
        @(negedge clock);
        b  = ref_meaning(ins);
        rs = ins[25:21];
        rt = ins[20:16];
        byp_rs = c_BYP && we && (wa == rs) && (rs != 0) && !(b.dest_en && b.dest == rs);
        byp_rt = c_BYP && we && (wa == rt) && (rt != 0) && !(b.dest_en && b.dest == rt);
        haz = (b.use_rs && m_pend[rs] && !byp_rs) || (b.use_rt && m_pend[rt] && !byp_rt);
        exp_rdy = (!m_full || ordy) && !haz;
        chk("in_ready", in_ready, exp_rdy);
        chk("stall", stall, v && haz);
        acc = v && exp_rdy;
        b.rs_val = byp_rs ? wd : m_regs[rs];
        b.rt_val = byp_rt ? wd : m_regs[rt];
        @(posedge clock);
        if (acc) exp_q.push_back(b);
        m_full = acc ? 1'b1 : (ordy ? 1'b0 : m_full);
        if (we) m_pend[wa] = 1'b0;
        if (acc && b.dest_en) m_pend[b.dest] = 1'b1;
        if (we && wa != 0) m_regs[wa] = wd;
        #1;
    endtask

    // Present an instruction until accepted, optionally writing back at cycle wb_k
    task automatic issue(input string name, input logic [31:0] ins, input bit ordy,
                         input int wb_k, input logic [4:0] wa, input logic [31:0] wd);
        bit acc;
        acc = 1'b0;
        for (int k = 0; k < 8 && !acc; k++) begin
            cycle(1'b1, ins, ordy, k == wb_k, wa, wd, acc);
        end
        chk(name, acc, 1'b1);
    endtask

    task automatic idle(input int n, input bit ordy);
        bit acc;
        for (int k = 0; k < n; k++) cycle(1'b0, 32'd0, ordy, 1'b0, 5'd0, 32'd0, acc);
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        bit acc;
        cycle(1'b0, 32'd0, 1'b1, 1'b1, a, d, acc);
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        in_instr  = 32'd0;
        out_ready = 1'b0;
        wb_en     = 1'b0;
        wb_addr   = 5'd0;
        wb_data   = 32'd0;
        reset_n   = 1'b0;
        @(posedge clock);
        model_reset();
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_dest_en", out_dest_en, 1'b0);
        chk("rst_out_rs_val", out_rs_val, 32'd0);
        chk("rst_out_imm", out_imm, 32'd0);
        chk("rst_out_opcode", out_opcode, 6'd0);
        reset_n = 1'b1;
    endtask

    // Monitor: compare the presented bundle while valid, retire on out_ready
    always @(negedge clock) begin
        if (reset_n) begin
            chk("out_valid", out_valid, exp_q.size() != 0);
            if (out_valid && exp_q.size() != 0) begin
                chk("out_opcode", out_opcode, exp_q[0].opcode);
                chk("out_funct", out_funct, exp_q[0].funct);
                chk("out_imm", out_imm, exp_q[0].imm);
                chk("out_dest_en", out_dest_en, exp_q[0].dest_en);
                if (exp_q[0].dest_en) chk("out_dest", out_dest, exp_q[0].dest);
                if (exp_q[0].use_rs)  chk("out_rs_val", out_rs_val, exp_q[0].rs_val);
                if (exp_q[0].use_rt)  chk("out_rt_val", out_rt_val, exp_q[0].rt_val);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        bit acc;
        logic [5:0] ops [15];
        ops = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A,
                6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h3F, 6'h11};

        model_reset();
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        do_reset();
        idle(1, 1'b1);

        // Basic R-type: add r7,r5,r6
        wb(5'd5, 32'h11);
        wb(5'd6, 32'h22);
        issue("rtype_accept", 32'h00A63820, 1'b1, -1, 5'd0, 32'd0);
        // r7 now pending: add r10,r7,r0 stalls until r7 written back
        issue("r7_dep_accept", 32'h00E05020, 1'b1, 2, 5'd7, 32'h33);

        // RAW: addi r8,r0,-1 then add r9,r8,r8
        issue("addi_accept", 32'h2008FFFF, 1'b1, -1, 5'd0, 32'd0);
        issue("raw_accept", 32'h01084820, 1'b1, 3, 5'd8, 32'hFFFF_FFFF);
        idle(1, 1'b1);
        wb(5'd9, 32'h99);

        // Back-pressure: hold a FULL bundle three cycles
        issue("bp_first", 32'h34021234, 1'b0, -1, 5'd0, 32'd0);
        for (int k = 0; k < 3; k++) cycle(1'b1, 32'h34030055, 1'b0, 1'b0, 5'd0, 32'd0, acc);
        issue("bp_second", 32'h34030055, 1'b1, -1, 5'd0, 32'd0);
        idle(1, 1'b1);
        wb(5'd2, 32'h2);
        wb(5'd3, 32'h3);

        // Register 0 and immediate forms
        wb(5'd0, 32'h0000DEAD);
        issue("ori_r0", 32'h34018000, 1'b1, -1, 5'd0, 32'd0);
        issue("addi_sext", 32'h20018000, 1'b1, 1, 5'd1, 32'h5);
        issue("lui", 32'h3C04ABCD, 1'b1, -1, 5'd0, 32'd0);
        idle(1, 1'b1);
        wb(5'd1, 32'h1);
        wb(5'd4, 32'h4);

        // Destination-less instructions and jal
        issue("sw", 32'hAC620000, 1'b1, -1, 5'd0, 32'd0);
        issue("beq", 32'h10220004, 1'b1, -1, 5'd0, 32'd0);
        issue("jr", 32'h03E00008, 1'b1, -1, 5'd0, 32'd0);
        issue("jal", 32'h0C000010, 1'b1, -1, 5'd0, 32'd0);
        issue("jr_after_jal", 32'h03E00008, 1'b1, 1, 5'd31, 32'h40);
        issue("j", 32'h0BFFFFFF, 1'b1, -1, 5'd0, 32'd0);

        // Reset while FULL with r3 pending
        wb(5'd3, 32'h1234_5678);
        issue("pre_reset", 32'h20030005, 1'b0, -1, 5'd0, 32'd0);
        do_reset();
        issue("post_reset", 32'h00632020, 1'b1, -1, 5'd0, 32'd0);
        idle(1, 1'b1);
        wb(5'd4, 32'h0);

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            logic [31:0] ins;
            logic [5:0]  op;
            logic [4:0]  wa;
            op  = ops[$urandom_range(0, 14)];
            ins = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
            if (op == 6'h00) begin
                ins[15:11] = 5'($urandom_range(0, 7));
                ins[5:0]   = ($urandom_range(0, 3) == 0) ? 6'h08 : 6'h20;
            end
            wa = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
            cycle($urandom_range(0, 4) != 0, ins, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 1) == 1, wa, $urandom, acc);
        end

        idle(4, 1'b1);
        chk("drain_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
